mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared op encoding, controller state encoding and memory
// geometry for mem_access_ctrl and its arbiter.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 7;
  localparam int DEPTH      = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } memOp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } ctrlState_t;

  // Push/pop address the stack bank; read/write address the RAM bank.
  function automatic logic isStackOp(input memOp_t op);
    return op[1];
  endfunction

  // Ops that drive MemWrite during SETUP.
  function automatic logic isWriteOp(input memOp_t op);
    return (op == OP_WRITE) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter. The requester that did not win
// the last accepted grant has priority; requester 0 has priority after reset.
module rr_arbiter2
  import mem_ctrl_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       Accept,
  output logic [1:0] Grant,
  output logic       GrantIdx
);

  logic prioR;

  // Choose the priority requester when it asks, otherwise the other one.
  always_comb begin
    GrantIdx = prioR;
    Grant    = 2'b00;
    if (Req[prioR]) begin
      GrantIdx = prioR;
    end else if (Req[~prioR]) begin
      GrantIdx = ~prioR;
    end else begin
      GrantIdx = prioR;
    end
    if (Req != 2'b00) begin
      Grant = GrantIdx ? 2'b10 : 2'b01;
    end else begin
      Grant = 2'b00;
    end
  end

  // Hand priority to the losing side whenever a grant is taken.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prioR <= 1'b0;
    end else if (Accept && (Req != 2'b00)) begin
      prioR <= ~GrantIdx;
    end else begin
      prioR <= prioR;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: two-requester controller for a RAM bank and a stack bank
// sharing one memory port. Optional stack over/underflow guard is enabled by
// defining MEM_STACK_GUARD_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int NREQ   = 2
)(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [2*NREQ-1:0] Op,
  input  logic [32*NREQ-1:0] Addr,
  input  logic [32*NREQ-1:0] WData,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Done,
  output logic [31:0]       RData,
  output logic              RErr,
  output logic [31:0]       MemDataIn,
  output logic [31:0]       MemAddr,
  output logic              MemWrite,
  output logic              MemUseStk,
  output logic              MemReadStb,
  input  logic [31:0]       MemDataOut,
  output logic [ADDR_W:0]   Sp,
  output logic              StkFull,
  output logic              StkEmpty,
  output logic              StkErr
);

  localparam logic [ADDR_W:0] SP_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};

  ctrlState_t stateR, stateN;
  memOp_t     opR, opN, winOp;
  logic [1:0] winGrant;
  logic       winIdx;
  logic [ADDR_W-1:0] winAddr;
  logic [31:0] winData;
  logic        guardHit;
  logic [ADDR_W:0] spDec;

  logic [1:0]  gntR, gntN, doneR, doneN;
  logic [31:0] rDataR, rDataN, memAddrR, memAddrN, memDataR, memDataN;
  logic        memWriteR, memWriteN, memUseStkR, memUseStkN, readStbR, readStbN;
  logic        rErrR, rErrN, stkErrR, stkErrN;
  logic [ADDR_W:0] spR, spN;

  // Upper address bits are don't-care by definition.
  logic unusedAddrHi;
  assign unusedAddrHi = ^{Addr[63:32+ADDR_W], Addr[31:ADDR_W]};

  rr_arbiter2 uArb (
    .Clock    (Clock),
    .Reset    (Reset),
    .Req      (Req),
    .Accept   (stateR == ST_IDLE),
    .Grant    (winGrant),
    .GrantIdx (winIdx)
  );

  assign winOp   = memOp_t'(Op[{winIdx, 1'b0} +: 2]);
  assign winAddr = Addr[{winIdx, 5'b00000} +: ADDR_W];
  assign winData = WData[{winIdx, 5'b00000} +: 32];
  assign spDec   = spR - SP_ONE;

  assign StkEmpty = (spR == {(ADDR_W+1){1'b0}});
  assign StkFull  = (spR == SP_FULL);

  // Stack guard decision for the current arbitration winner.
  always_comb begin
    guardHit = 1'b0;
`ifdef MEM_STACK_GUARD_EN
    if (((winOp == OP_PUSH) && StkFull) || ((winOp == OP_POP) && StkEmpty)) begin
      guardHit = 1'b1;
    end else begin
      guardHit = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic; every memory-side output is the
  // registered copy of a value computed here.
  always_comb begin
    stateN     = stateR;
    opN        = opR;
    gntN       = gntR;
    doneN      = 2'b00;
    rErrN      = 1'b0;
    memAddrN   = memAddrR;
    memDataN   = memDataR;
    memWriteN  = 1'b0;
    memUseStkN = memUseStkR;
    readStbN   = 1'b0;
    rDataN     = rDataR;
    spN        = spR;
    stkErrN    = stkErrR;
    case (stateR)
      ST_IDLE: begin
        if (Req != 2'b00) begin
          opN  = winOp;
          gntN = winGrant;
          if (guardHit) begin
            stateN  = ST_RESP;
            doneN   = winGrant;
            rErrN   = 1'b1;
            stkErrN = 1'b1;
          end else begin
            stateN     = ST_SETUP;
            memDataN   = winData;
            memUseStkN = isStackOp(winOp);
            memWriteN  = isWriteOp(winOp);
            case (winOp)
              OP_PUSH: memAddrN = {{(32-ADDR_W){1'b0}}, spR[ADDR_W-1:0]};
              OP_POP: begin
                spN      = spDec;
                memAddrN = {{(32-ADDR_W){1'b0}}, spDec[ADDR_W-1:0]};
              end
              default: memAddrN = {{(32-ADDR_W){1'b0}}, winAddr};
            endcase
          end
        end else begin
          stateN = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (isWriteOp(opR)) begin
          stateN = ST_RESP;
          doneN  = gntR;
          if (opR == OP_PUSH) begin
            spN = spR + SP_ONE;
          end else begin
            spN = spR;
          end
        end else begin
          stateN   = ST_STROBE;
          readStbN = 1'b1;
        end
      end
      ST_STROBE: begin
        stateN = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        stateN = ST_RESP;
        rDataN = MemDataOut;
        doneN  = gntR;
      end
      ST_RESP: begin
        stateN = ST_IDLE;
        gntN   = 2'b00;
      end
      default: begin
        stateN = ST_IDLE;
        gntN   = 2'b00;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateR <= ST_IDLE;
      opR    <= OP_READ;
    end else begin
      stateR <= stateN;
      opR    <= opN;
    end
  end

  // Registered outputs, stack pointer and sticky error.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      gntR       <= 2'b00;
      doneR      <= 2'b00;
      rErrR      <= 1'b0;
      memAddrR   <= 32'h0000_0000;
      memDataR   <= 32'h0000_0000;
      memWriteR  <= 1'b0;
      memUseStkR <= 1'b0;
      readStbR   <= 1'b0;
      rDataR     <= 32'h0000_0000;
      spR        <= {(ADDR_W+1){1'b0}};
      stkErrR    <= 1'b0;
    end else begin
      gntR       <= gntN;
      doneR      <= doneN;
      rErrR      <= rErrN;
      memAddrR   <= memAddrN;
      memDataR   <= memDataN;
      memWriteR  <= memWriteN;
      memUseStkR <= memUseStkN;
      readStbR   <= readStbN;
      rDataR     <= rDataN;
      spR        <= spN;
      stkErrR    <= stkErrN;
    end
  end

  assign Gnt        = gntR;
  assign Done       = doneR;
  assign RData      = rDataR;
  assign MemAddr    = memAddrR;
  assign MemDataIn  = memDataR;
  assign MemWrite   = memWriteR;
  assign MemUseStk  = memUseStkR;
  assign MemReadStb = readStbR;
  assign Sp         = spR;
`ifdef MEM_STACK_GUARD_EN
  assign RErr   = rErrR;
  assign StkErr = stkErrR;
`else
  assign RErr   = 1'b0;
  assign StkErr = 1'b0;
  logic unusedErr;
  assign unusedErr = rErrR ^ stkErrR;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench; RAM modelled as an
// array and the stack as a queue, independent of the controller internals.
module tb_mem_access_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [1:0]  Req = 2'b00;
  logic [3:0]  Op = 4'b0000;
  logic [63:0] Addr = 64'd0;
  logic [63:0] WData = 64'd0;
  logic [1:0]  Gnt, Done;
  logic [31:0] RData, MemDataIn, MemAddr;
  logic        RErr, MemWrite, MemUseStk, MemReadStb;
  logic [31:0] memOut = 32'd0;
  logic [7:0]  Sp;
  logic        StkFull, StkEmpty, StkErr;

  mem_access_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .WData(WData),
    .Gnt(Gnt), .Done(Done), .RData(RData), .RErr(RErr),
    .MemDataIn(MemDataIn), .MemAddr(MemAddr), .MemWrite(MemWrite),
    .MemUseStk(MemUseStk), .MemReadStb(MemReadStb), .MemDataOut(memOut),
    .Sp(Sp), .StkFull(StkFull), .StkEmpty(StkEmpty), .StkErr(StkErr)
  );

  always #5 Clock = ~Clock;

  // Memory banks attached to the controller's port.
  logic [31:0] bankRam [128] = '{default: 32'h0};
  logic [31:0] bankStk [128] = '{default: 32'h0};
  int writeCnt = 0, strobeCnt = 0, doneCnt = 0, bothDoneCnt = 0;

  always @(posedge Clock) begin
    if (MemWrite) begin
      if (MemUseStk) bankStk[MemAddr[6:0]] <= MemDataIn;
      else           bankRam[MemAddr[6:0]] <= MemDataIn;
    end
    if (MemReadStb) memOut <= MemUseStk ? bankStk[MemAddr[6:0]] : bankRam[MemAddr[6:0]];
    if (MemWrite)   writeCnt <= writeCnt + 1;
    if (MemReadStb) strobeCnt <= strobeCnt + 1;
    if (Done != 2'b00) doneCnt <= doneCnt + 1;
    if (Done == 2'b11) bothDoneCnt <= bothDoneCnt + 1;
  end

  // Reference model state.
  logic [31:0] refRam [128] = '{default: 32'h0};
  logic [31:0] refStk [$];
  logic [31:0] refRData = 32'h0;
  bit          refStkErr = 1'b0;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkResetOutputs();
    checkEq("rst_gnt", Gnt, 2'b00);
    checkEq("rst_done", Done, 2'b00);
    checkEq("rst_memwrite", MemWrite, 1'b0);
    checkEq("rst_readstb", MemReadStb, 1'b0);
    checkEq("rst_usestk", MemUseStk, 1'b0);
    checkEq("rst_memaddr", MemAddr, 32'h0);
    checkEq("rst_memdata", MemDataIn, 32'h0);
    checkEq("rst_rdata", RData, 32'h0);
    checkEq("rst_rerr", RErr, 1'b0);
    checkEq("rst_sp", Sp, 8'd0);
    checkEq("rst_stkerr", StkErr, 1'b0);
    checkEq("rst_empty", StkEmpty, 1'b1);
    checkEq("rst_full", StkFull, 1'b0);
  endtask

  // One complete transaction from a single requester, checked end to end.
  task automatic doOp(input int idx, input logic [1:0] op, input logic [6:0] a,
                      input logic [31:0] d, input bit dropEarly);
    logic [31:0] addrWord, expAddr;
    logic [1:0]  oneHot;
    int cyc, expLat, expWr, expStb, wc0, sc0;
    bit got, errExp, expStk;
    oneHot  = (idx == 0) ? 2'b01 : 2'b10;
    errExp  = 1'b0;
`ifdef MEM_STACK_GUARD_EN
    if ((op == 2'b10 && refStk.size() == 128) || (op == 2'b11 && refStk.size() == 0)) errExp = 1'b1;
`endif
    expStk  = op[1];
    expAddr = {25'd0, a};
    expLat = 2; expWr = 0; expStb = 0;
    if (errExp) begin
      expLat = 1;
      refStkErr = 1'b1;
    end else begin
      case (op)
        2'b00: begin expLat = 4; expStb = 1; refRData = refRam[a]; end
        2'b01: begin expLat = 2; expWr = 1; refRam[a] = d; end
        2'b10: begin expLat = 2; expWr = 1; expAddr = 32'(refStk.size()); refStk.push_back(d); end
        default: begin expLat = 4; expStb = 1; refRData = refStk.pop_back(); expAddr = 32'(refStk.size()); end
      endcase
    end
    addrWord = $urandom();
    addrWord[6:0] = a;
    Addr[32*idx +: 32]  = addrWord;
    WData[32*idx +: 32] = d;
    Op[2*idx +: 2]      = op;
    wc0 = writeCnt;
    sc0 = strobeCnt;
    Req[idx] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 16) begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1 && !errExp) begin
        checkEq("setup_gnt", Gnt, oneHot);
        checkEq("setup_addr", MemAddr, expAddr);
        checkEq("setup_bank", MemUseStk, expStk);
        checkEq("setup_wr", MemWrite, expWr);
        if (expWr != 0) checkEq("setup_wdata", MemDataIn, d);
      end
      if (cyc == 1 && dropEarly) Req[idx] = 1'b0;
      if (Done != 2'b00) got = 1'b1;
    end
    Req[idx] = 1'b0;
    checkEq("done_seen", got, 1'b1);
    checkEq("latency", cyc, expLat);
    checkEq("done_idx", Done, oneHot);
    checkEq("resp_gnt", Gnt, oneHot);
    checkEq("rdata", RData, refRData);
    checkEq("rerr", RErr, errExp);
    checkEq("sp", Sp, refStk.size());
    checkEq("stk_empty", StkEmpty, refStk.size() == 0);
    checkEq("stk_full", StkFull, refStk.size() == 128);
    checkEq("stk_err", StkErr, refStkErr);
    checkEq("mem_writes", writeCnt - wc0, expWr);
    checkEq("read_strobes", strobeCnt - sc0, expStb);
    @(negedge Clock);
    checkEq("gnt_drop", Gnt, 2'b00);
    checkEq("done_pulse", Done, 2'b00);
  endtask

  // Both requesters hold reads; grants must alternate starting at requester 0.
  task automatic dualReads(input logic [6:0] a0, input logic [6:0] a1);
    int cyc, winner, b0;
    bit got;
    logic [31:0] expD;
    b0 = bothDoneCnt;
    Op = 4'b0000;
    Addr = {25'h1abcdef, a1, 25'h0123456, a0};
    Req = 2'b11;
    for (int n = 0; n < 5; n++) begin
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 16) begin
        @(negedge Clock);
        cyc++;
        if (Done != 2'b00) got = 1'b1;
      end
      winner = n % 2;
      expD = refRam[(winner == 1) ? a1 : a0];
      refRData = expD;
      checkEq("dual_done_seen", got, 1'b1);
      checkEq("dual_order", Done, (winner == 0) ? 2'b01 : 2'b10);
      checkEq("dual_lat", cyc, (n == 4) ? 5 : 4);
      checkEq("dual_rdata", RData, expD);
      Req[winner] = 1'b0;
      if (n < 3) begin
        @(negedge Clock);
        Req[winner] = 1'b1;
      end
    end
    @(negedge Clock);
    checkEq("dual_gnt_drop", Gnt, 2'b00);
    checkEq("done_exclusive", bothDoneCnt - b0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ridx, d0;
    logic [1:0] rop;
    #2;
    checkResetOutputs();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // Write then read back through the RAM bank.
    doOp(0, 2'b01, 7'd5, 32'hDEADBEEF, 1'b0);
    doOp(0, 2'b00, 7'd5, 32'h0, 1'b0);

    // Push two, pop two.
    doOp(0, 2'b10, 7'd0, 32'h11, 1'b0);
    doOp(1, 2'b10, 7'd0, 32'h22, 1'b0);
    doOp(0, 2'b11, 7'd0, 32'h0, 1'b0);
    doOp(1, 2'b11, 7'd0, 32'h0, 1'b0);

    // Random single-requester traffic, sometimes dropping Req mid-op.
    for (int n = 0; n < 150; n++) begin
      ridx = $urandom_range(1, 0);
      rop  = 2'($urandom_range(3, 0));
      if (rop == 2'b10 && refStk.size() >= 128) rop = 2'b11;
      if (rop == 2'b11 && refStk.size() == 0) rop = 2'b10;
      doOp(ridx, rop, 7'($urandom_range(127, 0)), $urandom(), $urandom_range(3, 0) == 0);
    end

    // Reset during STROBE of a requester-0 read.
    d0 = doneCnt;
    Op[1:0] = 2'b00;
    Addr[31:0] = 32'd5;
    Req[0] = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    checkEq("strobe_before_reset", MemReadStb, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    Req[0] = 1'b0;
    refStk.delete();
    refRData = 32'h0;
    refStkErr = 1'b0;
    checkResetOutputs();
    repeat (3) @(negedge Clock);
    checkEq("no_done_after_abort", doneCnt - d0, 0);
    Reset = 1'b1;
    @(negedge Clock);
    dualReads(7'd5, 7'($urandom_range(127, 0)));

`ifdef MEM_STACK_GUARD_EN
    for (int k = 0; k < 128; k++) doOp(k % 2, 2'b10, 7'd0, $urandom(), 1'b0);
    doOp(0, 2'b10, 7'd0, 32'h55, 1'b0);
    for (int k = 0; k < 128; k++) doOp(k % 2, 2'b11, 7'd0, 32'h0, 1'b0);
    doOp(1, 2'b11, 7'd0, 32'h0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
